// File: rtl/rom_instrucoes.sv
// Instruction ROM with a valid/ready fetch port, a 1-cycle registered response and a load port.
// Faulted fetches (misaligned or past the last word) answer with NOP and erro set.
module rom_instrucoes #(
  parameter int                 LARGURA      = 32,
  parameter int                 PROFUNDIDADE = 64,
  parameter logic [LARGURA-1:0] NOP          = LARGURA'(32'h00000013),
  localparam int                END_W        = $clog2(PROFUNDIDADE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        endereco,
  input  logic               flush,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [LARGURA-1:0] saida,
  output logic               erro,
  input  logic               prog_en,
  input  logic [END_W-1:0]   prog_end,
  input  logic [LARGURA-1:0] prog_dado
);

  localparam logic [29:0]    DEPTH_IDX  = 30'(PROFUNDIDADE);
  localparam logic [END_W:0] DEPTH_PROG = (END_W + 1)'(PROFUNDIDADE);

  // NOTE: the array has no reset; it powers up cleared and keeps its contents across rst_n.
  logic [LARGURA-1:0] mem_q [PROFUNDIDADE] = '{default: '0};

  logic               resp_valid_q, resp_valid_d;
  logic               erro_q, erro_d;
  logic [LARGURA-1:0] saida_q, saida_d;

  logic               fault;
  logic               accept;
  logic [END_W-1:0]   idx;

  assign idx       = endereco[END_W+1:2];
  assign fault     = (endereco[1:0] != 2'b00) || (endereco[31:2] >= DEPTH_IDX);
  assign req_ready = (!resp_valid_q || resp_ready) && !flush;
  assign accept    = req_valid && req_ready;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    resp_valid_d = resp_valid_q;
    erro_d       = erro_q;
    saida_d      = saida_q;
    if (flush) begin
      resp_valid_d = 1'b0;
      erro_d       = 1'b0;
    end else if (accept) begin
      resp_valid_d = 1'b1;
      erro_d       = fault;
      saida_d      = fault ? NOP : mem_q[idx];
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // NOTE: non-blocking updates mean a fetch and a load of the same word at one edge see the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      erro_q       <= 1'b0;
      saida_q      <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      erro_q       <= erro_d;
      saida_q      <= saida_d;
    end
  end

  always_ff @(posedge clk) begin
    if (prog_en && ({1'b0, prog_end} < DEPTH_PROG)) begin
      mem_q[prog_end] <= prog_dado;
    end
  end

  assign resp_valid = resp_valid_q;
  assign erro       = erro_q;
  assign saida      = saida_q;

endmodule

// File: tb/tb_rom_instrucoes.sv
// Bench for rom_instrucoes: directed fetches push expected {erro, saida} into a scoreboard,
// a negedge monitor pops and compares on every response transfer.
module tb_rom_instrucoes;

  localparam logic [31:0] W0   = 32'h00900103;
  localparam logic [31:0] W1   = 32'h00510093;
  localparam logic [31:0] W2   = 32'h00102223;
  localparam logic [31:0] W3   = 32'h00502183;
  localparam logic [31:0] WNEW = 32'hDEADBEEF;
  localparam logic [32:0] EFLT = {1'b1, 32'h00000013};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] endereco;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] saida;
  logic        erro;
  logic        prog_en;
  logic [5:0]  prog_end;
  logic [31:0] prog_dado;

  rom_instrucoes #(
    .LARGURA     (32),
    .PROFUNDIDADE(64),
    .NOP         (32'h00000013)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .endereco  (endereco),
    .flush     (flush),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .saida     (saida),
    .erro      (erro),
    .prog_en   (prog_en),
    .prog_end  (prog_end),
    .prog_dado (prog_dado)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [32:0] sb[$];
  int          pop_cyc[$];
  logic [32:0] mon_exp;
  int          base;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a response transfers at the coming edge when valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready && !flush) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got %0h expected none", {erro, saida});
      end else begin
        mon_exp = sb.pop_front();
        check("resp", {31'b0, erro, saida}, {31'b0, mon_exp});
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input logic push, input logic [32:0] e);
    bit ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    endereco  = a;
    if (push) sb.push_back(e);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept of %0h", a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [5:0] i, input logic [31:0] d);
    prog_en   = 1'b1;
    prog_end  = i;
    prog_dado = d;
    @(posedge clk);
    #1;
    prog_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; endereco = '0; flush = 1'b0;
    resp_ready = 1'b1; prog_en = 1'b0; prog_end = '0; prog_dado = '0;

    // Reset state
    #2;
    check("rst_valid", resp_valid, 0);
    check("rst_erro", erro, 0);
    check("rst_saida", saida, 0);
    check("rst_ready", req_ready, 1);
    flush = 1'b1;
    #1 check("rst_flush_ready", req_ready, 0);
    flush = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 check("rst_no_accept", resp_valid, 0);
    req_valid = 1'b0;
    rst_n = 1'b1;

    // Load and back-to-back burst
    prog(6'd0, W0);
    prog(6'd1, W1);
    prog(6'd2, W2);
    prog(6'd3, W3);
    base = pop_cyc.size();
    fetch(32'h0, 1'b1, {1'b0, W0});
    fetch(32'h4, 1'b1, {1'b0, W1});
    fetch(32'h8, 1'b1, {1'b0, W2});
    fetch(32'hC, 1'b1, {1'b0, W3});
    idle(3);
    check("burst_count", pop_cyc.size() - base, 4);
    for (int k = 1; k < 4; k++)
      check("burst_gap", pop_cyc[base+k] - pop_cyc[base+k-1], 1);
    check("burst_drain_valid", resp_valid, 0);

    // Faults and range boundaries
    fetch(32'h6, 1'b1, EFLT);
    fetch(32'h100, 1'b1, EFLT);
    fetch(32'hFC, 1'b1, {1'b0, 32'h0});
    fetch(32'h8000_0000, 1'b1, EFLT);
    fetch(32'h14, 1'b1, {1'b0, 32'h0});
    idle(2);

    // Backpressure: response holds, next request waits, then goes same edge
    resp_ready = 1'b0;
    fetch(32'h4, 1'b1, {1'b0, W1});
    req_valid = 1'b1;
    endereco  = 32'h8;
    sb.push_back({1'b0, W2});
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", resp_valid, 1);
      check("stall_saida", saida, W1);
      check("stall_ready", req_ready, 0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    check("release_ready", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("release_accept", resp_valid, 1);
    idle(2);

    // Flush drops a pending faulted response and blocks a same-cycle request
    resp_ready = 1'b0;
    fetch(32'h2, 1'b0, EFLT);
    check("pre_flush_erro", erro, 1);
    req_valid = 1'b1;
    endereco  = 32'h0;
    flush     = 1'b1;
    #1 check("flush_ready", req_ready, 0);
    @(posedge clk);
    #1;
    check("flush_valid", resp_valid, 0);
    check("flush_erro", erro, 0);
    flush = 1'b0;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 check("flush_no_accept", resp_valid, 0);

    // Load and fetch of the same word at one edge
    prog_en   = 1'b1;
    prog_end  = 6'd2;
    prog_dado = WNEW;
    fetch(32'h8, 1'b1, {1'b0, W2});
    prog_en = 1'b0;
    fetch(32'h8, 1'b1, {1'b0, WNEW});
    idle(2);

    // Asynchronous reset between edges with a response pending
    resp_ready = 1'b0;
    fetch(32'h6, 1'b0, EFLT);
    req_valid = 1'b0;
    #1;
    check("pre_rst_valid", resp_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", resp_valid, 0);
    check("async_rst_erro", erro, 0);
    check("async_rst_saida", saida, 0);
    #1 rst_n = 1'b1;
    resp_ready = 1'b1;
    fetch(32'h0, 1'b1, {1'b0, W0});
    check("first_accept_after_rst", resp_valid, 1);
    fetch(32'h8, 1'b1, {1'b0, WNEW});
    fetch(32'h4, 1'b1, {1'b0, W1});
    idle(3);

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
